// File: rtl/mult_div_unit.sv
// mult_div_unit
// Sequential signed multiply/divide for the multicycle MIPS datapath.
// mult uses shift-add and div uses restoring shift-subtract. Both take WIDTH
// iterations on unsigned magnitudes, followed by one sign-fixup cycle.
//
// Ports
//   clk, reset      clock (rising edge); asynchronous active-high reset
//   start, op, a, b request; op 0 = mult, 1 = div; sampled with start
//   busy            operation in flight (RUN/FIX)
//   done            one-cycle completion pulse; results valid with it
//   div_zero        div with b == 0, reported with done
//   hi_out, lo_out  mult: product hi/lo; div: remainder/quotient
//
// state | meaning
// IDLE  | waiting for start
// RUN   | WIDTH magnitude iterations
// FIX   | sign correction, result write
// DONE  | done pulse; may accept the next start
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic               neg_res_q, neg_res_d;   // product / quotient sign
  logic               neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
  logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;           // product; low half is multiplier or dividend/quotient
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   rem_sh, div_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    // -2^(W-1) negates to itself, which is the correct unsigned magnitude
    mag_a  = a[WIDTH-1] ? (~a + ONE_W) : a;
    mag_b  = b[WIDTH-1] ? (~b + ONE_W) : b;
    accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: the remainder stays below the divisor, so the top bit of
    // the difference is a clean borrow.
    rem_sh   = {rem_q, acc_q[WIDTH-1]};
    div_diff = rem_sh - {2'b00, opnd_q};
    q_bit    = ~div_diff[WIDTH+1];

    prod_fix = neg_res_q ? (~acc_q + ONE_2W) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~rem_q[WIDTH-1:0] + ONE_W) : rem_q[WIDTH-1:0];

    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          op_d      = op;
          neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          cnt_d     = '0;
          rem_d     = '0;
          opnd_d    = op ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
          if (op && (b == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (op_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
          rem_d = q_bit ? div_diff[WIDTH:0] : rem_sh[WIDTH:0];
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit           m_dz = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic; SV / and % truncate toward zero and
  // give the remainder the dividend's sign. A zero divisor leaves hi/lo alone.
  function automatic void model(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p, q, r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    if (!o) begin
      p    = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
      m_dz = 1'b0;
    end else if (y == '0) begin
      m_dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      m_lo = q[31:0];
      m_hi = r[31:0];
      m_dz = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Call at a negedge; the following posedge is the accept edge.
  task automatic op_start(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    model(o, x, y);
  endtask

  // Waits for done, checking latency and results. Returns at the negedge on
  // which done is seen. glitch > 0 pulses a stray start that many cycles in.
  task automatic op_finish(input string tag, input int glitch);
    int n;
    int lat;
    lat = m_dz ? 0 : W + 1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    if (!m_dz) check({tag, " busy_run"}, 64'(busy), 64'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (glitch > 0 && n == glitch) begin
        start = 1'b1;
        op    = ~op;
        a     = $urandom;
        b     = $urandom;
      end else if (glitch > 0 && n == glitch + 1) begin
        start = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " hi"}, 64'(hi_out), 64'(m_hi));
    check({tag, " lo"}, 64'(lo_out), 64'(m_lo));
    check({tag, " div_zero"}, 64'(div_zero), 64'(m_dz));
    check({tag, " busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input int glitch);
    @(negedge clk);
    op_start(o, x, y);
    op_finish(tag, glitch);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz", 64'(div_zero), 64'd0);
    check("rst hi", 64'(hi_out), 64'd0);
    check("rst lo", 64'(lo_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mult_basic", 0);
    check("mult_basic hi_const", 64'(hi_out), 64'hFFFF_FFFF);
    check("mult_basic lo_const", 64'(lo_out), 64'hFFFF_FFEB);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mult_ext", 0);
    check("mult_ext hi_const", 64'(hi_out), 64'h4000_0000);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_neg_pos", 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_pos_neg", 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 0);
    check("div_min_m1 lo_const", 64'(lo_out), 64'h8000_0000);

    run_op(1'b1, 32'h692, 32'h20, "div_prep", 0);
    run_op(1'b1, 32'd5, 32'd0, "div0", 0);
    check("div0 hi_hold", 64'(hi_out), 64'h12);
    check("div0 lo_hold", 64'(lo_out), 64'h34);

    run_op(1'b0, 32'd12345, 32'hFFFF_FD5A, "glitch", 5);

    @(negedge clk);
    op_start(1'b0, 32'd100, 32'd200);
    op_finish("b2b1", 0);
    op_start(1'b1, 32'hFFFF_FF9C, 32'd7);
    op_finish("b2b2", 0);
    op_start(1'b1, 32'd9, 32'd0);
    op_finish("b2b_div0", 0);
    @(negedge clk);
    check("b2b done_pulse", 64'(done), 64'd0);

    @(negedge clk);
    op_start(1'b1, 32'd1000, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid hi", 64'(hi_out), 64'd0);
    check("rst_mid lo", 64'(lo_out), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_mid no_done", 64'(saw_done), 64'd0);
    run_op(1'b0, 32'd3, 32'd4, "after_rst", 0);
    check("after_rst lo_const", 64'(lo_out), 64'd12);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), pick(), pick(), $sformatf("rand%0d", i), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
